// File: rtl/mem_pkg.sv
// Shared memory-command encodings, default widths and RAM owner encoding
// used by the CPU memory port and the arbiter.
package mem_pkg;
   localparam logic [1:0] MNONE  = 2'b00;
   localparam logic [1:0] MREAD  = 2'b01;
   localparam logic [1:0] MWRITE = 2'b10;

   localparam int AW_DEF = 8;
   localparam int DW_DEF = 16;

   typedef enum logic [1:0] {
      OWN_IDLE = 2'b00,
      OWN_CPU  = 2'b01,
      OWN_DMA  = 2'b10
   } owner_e;

   // 2'b11 is deliberately not a memory operation
   function automatic logic is_mem_op(input logic [1:0] cmd);
      return (cmd == MREAD) || (cmd == MWRITE);
   endfunction
endpackage

// File: rtl/req_fifo.sv
// Small synchronous FIFO for queued DMA requests, carried as one packed
// {cmd, addr, wdata} word. Asynchronous active-low reset clears pointers/count.
module req_fifo #(
   parameter int W     = 26,
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [W-1:0]             wdata,
   input  logic                     pop,
   output logic [W-1:0]             rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic          do_push, do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end
endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: CPU always wins with zero latency, DMA requests are
// queued and issued in CPU-idle cycles. Optional stats via MEM_ARB_STATS_EN.
module mem_arbiter import mem_pkg::*; #(
   parameter int AW         = AW_DEF,
   parameter int DW         = DW_DEF,
   parameter int FIFO_DEPTH = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [1:0]    cpu_mem_cmd,
   input  logic [AW-1:0] cpu_mem_addr,
   input  logic [DW-1:0] cpu_write_data,
   output logic [DW-1:0] cpu_read_data,
   input  logic          dma_valid,
   output logic          dma_ready,
   input  logic [1:0]    dma_cmd,
   input  logic [AW-1:0] dma_addr,
   input  logic [DW-1:0] dma_wdata,
   output logic [DW-1:0] dma_rdata,
   output logic          dma_rvalid,
   output logic          dma_pending,
   output logic [AW-1:0] ram_addr,
   output logic          ram_write,
   output logic [DW-1:0] ram_din,
   input  logic [DW-1:0] ram_dout
`ifdef MEM_ARB_STATS_EN
   ,
   output logic [15:0]   dma_wait_cnt,
   output logic [15:0]   dma_wait_max
`endif
);
   localparam int FW = 2 + AW + DW;

   owner_e                      own;
   logic [FW-1:0]               head;
   logic [1:0]                  head_cmd;
   logic [AW-1:0]               head_addr;
   logic [DW-1:0]               head_wdata;
   logic                        full, empty, push, pop;
   logic [$clog2(FIFO_DEPTH):0] count;
   logic [AW-1:0]               last_addr;
   logic                        rd_pend;
   logic [DW-1:0]               rdata_q;

   assign {head_cmd, head_addr, head_wdata} = head;

   // Illegal DMA commands still complete the handshake but are never queued
   assign dma_ready   = reset && !full;
   assign push        = dma_valid && dma_ready && is_mem_op(dma_cmd);
   assign pop         = (own == OWN_DMA);
   assign dma_pending = reset && (count != '0);

   req_fifo #(.W(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (reset),
      .push  (push),
      .wdata ({dma_cmd, dma_addr, dma_wdata}),
      .pop   (pop),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   always_comb begin
      own = OWN_IDLE;
      if (is_mem_op(cpu_mem_cmd)) own = OWN_CPU;
      else if (!empty)            own = OWN_DMA;
   end

   always_comb begin
      ram_addr  = last_addr;
      ram_din   = cpu_write_data;
      ram_write = 1'b0;
      case (own)
         OWN_CPU: begin
            ram_addr  = cpu_mem_addr;
            ram_write = (cpu_mem_cmd == MWRITE);
         end
         OWN_DMA: begin
            ram_addr  = head_addr;
            ram_din   = head_wdata;
            ram_write = (head_cmd == MWRITE);
         end
         default: ;
      endcase
      if (!reset) ram_write = 1'b0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_addr <= '0;
         rd_pend   <= 1'b0;
         rdata_q   <= '0;
      end else begin
         if (own != OWN_IDLE) last_addr <= ram_addr;
         rd_pend <= pop && (head_cmd == MREAD);
         if (rd_pend) rdata_q <= ram_dout;
      end
   end

   // Sync RAM data lands the cycle after issue; hold it afterwards
   assign dma_rvalid    = rd_pend;
   assign dma_rdata     = rd_pend ? ram_dout : rdata_q;
   assign cpu_read_data = ram_dout;

`ifdef MEM_ARB_STATS_EN
   logic [15:0] wait_cnt, wait_max, cnt_nxt;

   always_comb begin
      cnt_nxt = wait_cnt;
      if (pop)
         cnt_nxt = '0;
      else if (!empty && (own == OWN_CPU) && (wait_cnt != 16'hFFFF))
         cnt_nxt = wait_cnt + 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wait_cnt <= '0;
         wait_max <= '0;
      end else begin
         wait_cnt <= cnt_nxt;
         if (cnt_nxt > wait_max) wait_max <= cnt_nxt;
      end
   end

   assign dma_wait_cnt = wait_cnt;
   assign dma_wait_max = wait_max;
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios then random traffic,
// checked against a queue-based request model and a behavioural RAM image.
module tb_mem_arbiter;
   localparam int AW = 8, DW = 16, DEPTH = 2;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [1:0]    cpu_mem_cmd = '0;
   logic [AW-1:0] cpu_mem_addr = '0;
   logic [DW-1:0] cpu_write_data = '0;
   logic [DW-1:0] cpu_read_data;
   logic          dma_valid = 1'b0;
   logic          dma_ready;
   logic [1:0]    dma_cmd = '0;
   logic [AW-1:0] dma_addr = '0;
   logic [DW-1:0] dma_wdata = '0;
   logic [DW-1:0] dma_rdata;
   logic          dma_rvalid;
   logic          dma_pending;
   logic [AW-1:0] ram_addr;
   logic          ram_write;
   logic [DW-1:0] ram_din;
   logic [DW-1:0] ram_dout = '0;
`ifdef MEM_ARB_STATS_EN
   logic [15:0]   dma_wait_cnt, dma_wait_max;
`endif

   mem_arbiter #(.AW(AW), .DW(DW), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset),
      .cpu_mem_cmd(cpu_mem_cmd), .cpu_mem_addr(cpu_mem_addr),
      .cpu_write_data(cpu_write_data), .cpu_read_data(cpu_read_data),
      .dma_valid(dma_valid), .dma_ready(dma_ready), .dma_cmd(dma_cmd),
      .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_rdata(dma_rdata),
      .dma_rvalid(dma_rvalid), .dma_pending(dma_pending),
      .ram_addr(ram_addr), .ram_write(ram_write), .ram_din(ram_din),
      .ram_dout(ram_dout)
`ifdef MEM_ARB_STATS_EN
      , .dma_wait_cnt(dma_wait_cnt), .dma_wait_max(dma_wait_max)
`endif
   );

   always #5 clk = ~clk;

   // Synchronous single-port RAM, read-before-write
   logic [DW-1:0] ram [256];
   always @(posedge clk) begin
      if (ram_write) ram[ram_addr] <= ram_din;
      ram_dout <= ram[ram_addr];
   end

   typedef struct {
      logic [1:0]  cmd;
      logic [7:0]  addr;
      logic [15:0] wd;
   } req_t;

   req_t        q[$];
   logic [15:0] mm [256];
   bit          rv_exp, crd_exp, known;
   logic [15:0] rv_dat, crd_dat;
   logic [7:0]  last_a;
   int          checks = 0, errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive at negedge, check #1 later, advance model, wait edge
   task automatic cyc(input logic [1:0] cc, input logic [7:0] ca, input logic [15:0] cw,
                      input logic dv, input logic [1:0] dc, input logic [7:0] da,
                      input logic [15:0] dw);
      bit cpu, iss, ew, rdy;
      logic [7:0]  ea;
      logic [15:0] ed;
      cpu_mem_cmd = cc; cpu_mem_addr = ca; cpu_write_data = cw;
      dma_valid = dv; dma_cmd = dc; dma_addr = da; dma_wdata = dw;
      #1;
      rdy = (q.size() < DEPTH);
      chk("dma_ready", 32'(dma_ready), 32'(rdy));
      chk("dma_pending", 32'(dma_pending), 32'(q.size() != 0));
      chk("dma_rvalid", 32'(dma_rvalid), 32'(rv_exp));
      if (rv_exp) chk("dma_rdata", 32'(dma_rdata), 32'(rv_dat));
      if (crd_exp) chk("cpu_read_data", 32'(cpu_read_data), 32'(crd_dat));
      cpu = (cc == 2'd1) || (cc == 2'd2);
      iss = !cpu && (q.size() > 0);
      ew = 0; ea = last_a; ed = cw;
      if (cpu) begin
         ea = ca; ew = (cc == 2'd2); ed = cw;
      end else if (iss) begin
         ea = q[0].addr; ew = (q[0].cmd == 2'd2); ed = q[0].wd;
      end
      chk("ram_write", 32'(ram_write), 32'(ew));
      if (cpu || iss || known) chk("ram_addr", 32'(ram_addr), 32'(ea));
      if (ew) chk("ram_din", 32'(ram_din), 32'(ed));
      rv_exp  = iss && (q[0].cmd == 2'd1);
      rv_dat  = mm[ea];
      crd_exp = cpu && (cc == 2'd1);
      crd_dat = mm[ea];
      if (ew) mm[ea] = ed;
      if (cpu || iss) begin last_a = ea; known = 1; end
      if (iss) void'(q.pop_front());
      if (dv && rdy && ((dc == 2'd1) || (dc == 2'd2))) q.push_back('{dc, da, dw});
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(2'd0, 8'h00, 16'h0, 1'b0, 2'd0, 8'h00, 16'h0);
   endtask

   // Assert reset with busy-looking inputs, check forced outputs, flush the model
   task automatic do_reset(input int n);
      reset = 1'b0; cpu_mem_cmd = 2'd2; cpu_mem_addr = 8'hAA;
      dma_valid = 1'b1; dma_cmd = 2'd1;
      #1;
      chk("rst_ram_write", 32'(ram_write), 32'd0);
      chk("rst_dma_ready", 32'(dma_ready), 32'd0);
      chk("rst_dma_rvalid", 32'(dma_rvalid), 32'd0);
      chk("rst_dma_pending", 32'(dma_pending), 32'd0);
      chk("rst_dma_rdata", 32'(dma_rdata), 32'd0);
      repeat (n) @(posedge clk);
      @(negedge clk);
      chk("rst_hold_ram_write", 32'(ram_write), 32'd0);
      chk("rst_hold_dma_ready", 32'(dma_ready), 32'd0);
      q.delete(); rv_exp = 0; crd_exp = 0; known = 0;
      reset = 1'b1; dma_valid = 1'b0; cpu_mem_cmd = 2'd0;
   endtask

   initial begin
      logic [1:0] rc;
      int         hold;
      for (int i = 0; i < 256; i++) begin
         ram[i] = 16'($urandom);
         mm[i]  = ram[i];
      end
      ram[5] = 16'h1234; mm[5] = 16'h1234;
      rv_exp = 0; crd_exp = 0; known = 0; last_a = '0;

      // Reset behaviour, then idle after release
      @(negedge clk);
      do_reset(3);
      idle(1);

      // CPU read of RAM[5]
      cyc(2'd1, 8'h05, 16'h0, 1'b0, 2'd0, 8'h00, 16'h0);
      idle(1);

      // DMA write then read-back of the same address
      cyc(2'd0, 8'h00, 16'h0, 1'b1, 2'd2, 8'h10, 16'hBEEF);
      cyc(2'd0, 8'h00, 16'h0, 1'b1, 2'd1, 8'h10, 16'h0);
      idle(3);

      // DMA read blocked by a 3-cycle CPU read
      cyc(2'd1, 8'h20, 16'h0, 1'b1, 2'd1, 8'h10, 16'h0);
      cyc(2'd1, 8'h20, 16'h0, 1'b0, 2'd0, 8'h00, 16'h0);
      cyc(2'd1, 8'h20, 16'h0, 1'b0, 2'd0, 8'h00, 16'h0);
      idle(3);

      // Fill the FIFO behind CPU traffic, third request held off
      cyc(2'd2, 8'h30, 16'h5555, 1'b1, 2'd2, 8'h40, 16'h1111);
      cyc(2'd1, 8'h31, 16'h0,    1'b1, 2'd2, 8'h41, 16'h2222);
      cyc(2'd1, 8'h32, 16'h0,    1'b1, 2'd1, 8'h40, 16'h0);
      cyc(2'd0, 8'h00, 16'h0,    1'b1, 2'd1, 8'h40, 16'h0);
      cyc(2'd0, 8'h00, 16'h0,    1'b1, 2'd1, 8'h40, 16'h0);
      idle(4);

      // Discarded command codes 00/11 complete but queue nothing
      cyc(2'd1, 8'h33, 16'h0, 1'b1, 2'd3, 8'h50, 16'hAAAA);
      cyc(2'd3, 8'h34, 16'h0, 1'b1, 2'd0, 8'h51, 16'hBBBB);
      idle(2);

      // Reset the cycle after a DMA read issues, with another request queued
      cyc(2'd0, 8'h00, 16'h0, 1'b1, 2'd1, 8'h41, 16'h0);
      cyc(2'd0, 8'h00, 16'h0, 1'b1, 2'd2, 8'h42, 16'h7777);
      do_reset(2);
      idle(4);

      // Random traffic on a small address window
      hold = 0; rc = 2'd0;
      repeat (400) begin
         if (hold == 0) begin
            rc   = 2'($urandom_range(0, 3));
            hold = $urandom_range(1, 3);
         end
         hold--;
         cyc(rc, 8'($urandom_range(0, 15)), 16'($urandom),
             1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             8'($urandom_range(0, 15)), 16'($urandom));
      end
      idle(4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
